// File: rtl/orpsoc_jtag_pkg.sv
// -----------------------------------------------------------------------------
// orpsoc_jtag_pkg
// Shared definitions for the ORPSoC JTAG TAP controller:
//   - tap_state_t : the 16 IEEE 1149.1 TAP states, 4-bit encoding
//   - IR_*        : 4-bit instruction opcodes and the IR capture pattern
//   - dr_sel_t    : which data register the current instruction selects
// Optional feature macro used by importers: JTAG_TAP_USERCODE_EN
// -----------------------------------------------------------------------------
package orpsoc_jtag_pkg;

    // Classic 1149.1 state encoding (matches common reference TAPs).
    typedef enum logic [3:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [3:0] IR_EXTEST         = 4'b0000;
    localparam logic [3:0] IR_SAMPLE_PRELOAD = 4'b0001;
    localparam logic [3:0] IR_IDCODE         = 4'b0010;
    localparam logic [3:0] IR_USERCODE       = 4'b0011;
    localparam logic [3:0] IR_DEBUG          = 4'b1000;
    localparam logic [3:0] IR_MBIST          = 4'b1001;
    localparam logic [3:0] IR_BYPASS         = 4'b1111;

    // Loaded into the IR shift register in CAPTURE_IR (LSBs "01" per 1149.1).
    localparam logic [3:0] IR_CAPTURE        = 4'b0101;

    typedef enum logic [1:0] {
        DR_BYPASS   = 2'd0,
        DR_IDCODE   = 2'd1,
        DR_USERCODE = 2'd2,
        DR_DEBUG    = 2'd3
    } dr_sel_t;

endpackage

// File: rtl/orpsoc_jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// orpsoc_jtag_tap_fsm
// The 16-state IEEE 1149.1 TAP state machine: one transition per rising tck
// edge, steered by tms. State-decode outputs are combinational from the state
// register so they line up with the state without extra latency.
// Ports:
//   tck_i                 in   JTAG clock
//   trst_n_i              in   async active-low reset -> TEST_LOGIC_RESET
//   tms_i                 in   test mode select
//   state_o               out  current state (tap_state_t encoding)
//   test_logic_reset_o .. update_dr_o  out  one-hot state decodes
// -----------------------------------------------------------------------------
module orpsoc_jtag_tap_fsm
    import orpsoc_jtag_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_n_i,
    input  logic       tms_i,
    output logic [3:0] state_o,
    output logic       test_logic_reset_o,
    output logic       run_test_idle_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       pause_dr_o,
    output logic       update_dr_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge tck_i or negedge trst_n_i) begin
        if (!trst_n_i) state_q <= TAP_TEST_LOGIC_RESET;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TEST_LOGIC_RESET: state_d = tms_i ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    state_d = tms_i ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        state_d = tms_i ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       state_d = tms_i ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         state_d = tms_i ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         state_d = tms_i ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         state_d = tms_i ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         state_d = tms_i ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        state_d = tms_i ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        state_d = tms_i ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       state_d = tms_i ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         state_d = tms_i ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         state_d = tms_i ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         state_d = tms_i ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         state_d = tms_i ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        state_d = tms_i ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            default:              state_d = TAP_TEST_LOGIC_RESET;
        endcase
    end

    always_comb begin
        state_o            = state_q;
        test_logic_reset_o = (state_q == TAP_TEST_LOGIC_RESET);
        run_test_idle_o    = (state_q == TAP_RUN_TEST_IDLE);
        capture_dr_o       = (state_q == TAP_CAPTURE_DR);
        shift_dr_o         = (state_q == TAP_SHIFT_DR);
        pause_dr_o         = (state_q == TAP_PAUSE_DR);
        update_dr_o        = (state_q == TAP_UPDATE_DR);
    end

endmodule

// File: rtl/orpsoc_jtag_tap.sv
// -----------------------------------------------------------------------------
// orpsoc_jtag_tap
// IEEE 1149.1 TAP controller sitting between the JTAG pads and the debug unit.
// Holds the instruction register, the IDCODE and BYPASS data registers and
// the falling-edge TDO register; the TAP FSM lives in orpsoc_jtag_tap_fsm.
// Optional feature: define JTAG_TAP_USERCODE_EN to add a 32-bit USERCODE DR
// (opcode 0011); otherwise that opcode behaves as BYPASS.
// Ports:
//   tck_pad_i, trst_n_pad_i, tms_pad_i, tdi_pad_i   JTAG pins in
//   tdo_pad_o, tdo_padoe_o                          JTAG data out + enable
//   test_logic_reset_o .. update_dr_o               TAP state decodes
//   debug_select_o                                  IR holds DEBUG
//   debug_tdi_o / debug_tdo_i                       serial link to debug chain
// -----------------------------------------------------------------------------
module orpsoc_jtag_tap
    import orpsoc_jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h14951185,
    parameter logic [31:0] USERCODE_VAL = 32'h00000000
) (
    input  logic tck_pad_i,
    input  logic trst_n_pad_i,
    input  logic tms_pad_i,
    input  logic tdi_pad_i,
    output logic tdo_pad_o,
    output logic tdo_padoe_o,
    output logic test_logic_reset_o,
    output logic run_test_idle_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic debug_select_o,
    output logic debug_tdi_o,
    input  logic debug_tdo_i
);

    logic [3:0]          state_w;
    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_latch_q, ir_latch_d;
    logic [31:0]         idcode_q, idcode_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;
    dr_sel_t             dr_sel;
    logic                dr_tdo;

    orpsoc_jtag_tap_fsm u_fsm (
        .tck_i              (tck_pad_i),
        .trst_n_i           (trst_n_pad_i),
        .tms_i              (tms_pad_i),
        .state_o            (state_w),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o)
    );

    assign state       = tap_state_t'(state_w);
    assign debug_tdi_o = tdi_pad_i;

    // Instruction decode; anything without a real DR behind it is BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir_latch_q)
            IR_WIDTH'(IR_IDCODE):         dr_sel = DR_IDCODE;
            IR_WIDTH'(IR_DEBUG):          dr_sel = DR_DEBUG;
`ifdef JTAG_TAP_USERCODE_EN
            IR_WIDTH'(IR_USERCODE):       dr_sel = DR_USERCODE;
`else
            IR_WIDTH'(IR_USERCODE):       dr_sel = DR_BYPASS;
`endif
            IR_WIDTH'(IR_EXTEST),
            IR_WIDTH'(IR_SAMPLE_PRELOAD),
            IR_WIDTH'(IR_MBIST),
            IR_WIDTH'(IR_BYPASS):         dr_sel = DR_BYPASS;
            default:                      dr_sel = DR_BYPASS;
        endcase
    end

    assign debug_select_o = (dr_sel == DR_DEBUG);

    // IR: capture fixed pattern, shift right with tdi at the MSB, and only
    // commit to the latch when leaving UPDATE_IR so a partial scan is harmless.
    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_latch_d = ir_latch_q;
        case (state)
            TAP_CAPTURE_IR:       ir_shift_d = IR_WIDTH'(IR_CAPTURE);
            TAP_SHIFT_IR:         ir_shift_d = {tdi_pad_i, ir_shift_q[IR_WIDTH-1:1]};
            TAP_UPDATE_IR:        ir_latch_d = ir_shift_q;
            TAP_TEST_LOGIC_RESET: ir_latch_d = IR_WIDTH'(IR_IDCODE);
            default: ;
        endcase
    end

    always_comb begin
        idcode_d = idcode_q;
        bypass_d = bypass_q;
        if (state == TAP_CAPTURE_DR) begin
            if (dr_sel == DR_IDCODE) idcode_d = IDCODE_VALUE;
            if (dr_sel == DR_BYPASS) bypass_d = 1'b0;
        end else if (state == TAP_SHIFT_DR) begin
            if (dr_sel == DR_IDCODE) idcode_d = {tdi_pad_i, idcode_q[31:1]};
            if (dr_sel == DR_BYPASS) bypass_d = tdi_pad_i;
        end
    end

    always_ff @(posedge tck_pad_i or negedge trst_n_pad_i) begin
        if (!trst_n_pad_i) begin
            ir_shift_q <= '0;
            ir_latch_q <= IR_WIDTH'(IR_IDCODE);
            idcode_q   <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_latch_q <= ir_latch_d;
            idcode_q   <= idcode_d;
            bypass_q   <= bypass_d;
        end
    end

`ifdef JTAG_TAP_USERCODE_EN
    logic [31:0] usercode_q, usercode_d;

    always_comb begin
        usercode_d = usercode_q;
        if (dr_sel == DR_USERCODE) begin
            if (state == TAP_CAPTURE_DR)    usercode_d = USERCODE_VAL;
            else if (state == TAP_SHIFT_DR) usercode_d = {tdi_pad_i, usercode_q[31:1]};
        end
    end

    always_ff @(posedge tck_pad_i or negedge trst_n_pad_i) begin
        if (!trst_n_pad_i) usercode_q <= '0;
        else               usercode_q <= usercode_d;
    end
`else
    logic unused_usercode_val;
    assign unused_usercode_val = ^USERCODE_VAL;
`endif

    always_comb begin
        case (dr_sel)
            DR_IDCODE:   dr_tdo = idcode_q[0];
            DR_DEBUG:    dr_tdo = debug_tdo_i;
`ifdef JTAG_TAP_USERCODE_EN
            DR_USERCODE: dr_tdo = usercode_q[0];
`endif
            default:     dr_tdo = bypass_q;
        endcase
    end

    // TDO is launched on the falling edge so the host can sample it cleanly
    // on the following rising edge.
    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo_d    = ir_shift_q[0];
            tdo_oe_d = 1'b1;
        end else if (state == TAP_SHIFT_DR) begin
            tdo_d    = dr_tdo;
            tdo_oe_d = 1'b1;
        end
    end

    always_ff @(negedge tck_pad_i or negedge trst_n_pad_i) begin
        if (!trst_n_pad_i) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign tdo_pad_o   = tdo_q;
    assign tdo_padoe_o = tdo_oe_q;

endmodule

// File: tb/tb_orpsoc_jtag_tap.sv
// Bench for orpsoc_jtag_tap: acts as the JTAG host, driving tms/tdi after the
// falling edge and taking tdo as the value present at the next rising edge.
module tb_orpsoc_jtag_tap;

    localparam logic [31:0] IDCODE   = 32'h14951185;
    localparam logic [31:0] USERCODE = 32'hCAFE0001;

    logic tck_pad_i = 1'b0;
    logic trst_n_pad_i, tms_pad_i, tdi_pad_i, debug_tdo_i;
    logic tdo_pad_o, tdo_padoe_o, test_logic_reset_o, run_test_idle_o;
    logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o;
    logic debug_select_o, debug_tdi_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   upd_cnt  = 0;
    logic exp_q[$];

    orpsoc_jtag_tap #(
        .IR_WIDTH     (4),
        .IDCODE_VALUE (IDCODE),
        .USERCODE_VAL (USERCODE)
    ) dut (
        .tck_pad_i          (tck_pad_i),
        .trst_n_pad_i       (trst_n_pad_i),
        .tms_pad_i          (tms_pad_i),
        .tdi_pad_i          (tdi_pad_i),
        .tdo_pad_o          (tdo_pad_o),
        .tdo_padoe_o        (tdo_padoe_o),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o),
        .debug_select_o     (debug_select_o),
        .debug_tdi_o        (debug_tdi_o),
        .debug_tdo_i        (debug_tdo_i)
    );

    always #10 tck_pad_i = ~tck_pad_i;

    always @(negedge tck_pad_i) if (update_dr_o) upd_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TAP clock: returns the tdo value the host sees at this rising edge.
    task automatic step(input logic tms, input logic tdi, input logic dbg, output logic seen);
        seen        = tdo_pad_o;
        tms_pad_i   = tms;
        tdi_pad_i   = tdi;
        debug_tdo_i = dbg;
        @(posedge tck_pad_i);
        @(negedge tck_pad_i);
        #1;
    endtask

    task automatic tms_go(input string s);
        logic b;
        for (int i = 0; i < s.len(); i++) step(s[i] == 8'h31, 1'b0, 1'b0, b);
    endtask

    // From RUN_TEST_IDLE: IR scan of op, back to RUN_TEST_IDLE.
    task automatic ir_scan(input logic [3:0] op, output logic [3:0] cap);
        logic b;
        tms_go("1100");
        for (int i = 0; i < 4; i++) begin
            step(i == 3, op[i], 1'b0, b);
            cap[i] = b;
        end
        tms_go("10");
    endtask

    // From RUN_TEST_IDLE: DR scan of n bits; expected tdo bits go through the scoreboard.
    task automatic dr_scan(input string tag, input int n, input logic [63:0] tdi_v,
                           input logic [64:0] dbg_v, input logic [63:0] exp_v);
        logic b;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_v[i]);
        tms_go("10");
        step(1'b0, 1'b0, dbg_v[0], b);
        chk({tag, "_oe"}, {31'd0, tdo_padoe_o}, 32'd1);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, tdi_v[i], dbg_v[i+1], b);
            if (exp_q.size() == 0) chk({tag, "_underflow"}, 32'd1, 32'd0);
            else chk($sformatf("%s_bit%0d", tag, i), {31'd0, b}, {31'd0, exp_q.pop_front()});
        end
        tms_go("10");
    endtask

    string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                         "01011", "011", "0110", "01100", "01101", "011010",
                         "0110101", "011011"};
    // {capture_dr, shift_dr, pause_dr, update_dr, run_test_idle, test_logic_reset}
    logic [5:0] decs[16] = '{6'b000001, 6'b000010, 6'b000000, 6'b100000, 6'b010000,
                             6'b000000, 6'b001000, 6'b000000, 6'b000100, 6'b000000,
                             6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                             6'b000000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cap;
        logic       b;
        int         u0;

        trst_n_pad_i = 1'b0;
        tms_pad_i    = 1'b1;
        tdi_pad_i    = 1'b0;
        debug_tdo_i  = 1'b0;
        repeat (2) @(negedge tck_pad_i);
        #1;
        chk("rst_tlr", {31'd0, test_logic_reset_o}, 32'd1);
        chk("rst_tdo", {31'd0, tdo_pad_o}, 32'd0);
        chk("rst_oe", {31'd0, tdo_padoe_o}, 32'd0);
        chk("rst_dbgsel", {31'd0, debug_select_o}, 32'd0);
        trst_n_pad_i = 1'b1;
        step(1'b1, 1'b0, 1'b0, b);
        chk("tlr_hold", {31'd0, test_logic_reset_o}, 32'd1);

        // Reset in the middle of a BYPASS DR scan.
        tms_go("0");
        ir_scan(4'b1111, cap);
        chk("ir_cap_bypass", {28'd0, cap}, 32'h5);
        tms_go("100");
        step(1'b0, 1'b1, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        chk("mid_shift", {31'd0, shift_dr_o}, 32'd1);
        u0 = upd_cnt;
        trst_n_pad_i = 1'b0;
        #2;
        chk("abort_tlr", {31'd0, test_logic_reset_o}, 32'd1);
        chk("abort_oe", {31'd0, tdo_padoe_o}, 32'd0);
        chk("abort_tdo", {31'd0, tdo_pad_o}, 32'd0);
        #3;
        trst_n_pad_i = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, b);
        chk("abort_no_update", upd_cnt - u0, 32'd0);
        chk("abort_tlr2", {31'd0, test_logic_reset_o}, 32'd1);

        // IR back to IDCODE after reset: read the 32-bit ID.
        tms_go("0");
        chk("rti", {31'd0, run_test_idle_o}, 32'd1);
        dr_scan("idcode", 32, 64'd0, 65'd0, {32'd0, IDCODE});

        // BYPASS: one tck of delay, leading captured zero.
        ir_scan(4'b1111, cap);
        chk("bypass_dbgsel", {31'd0, debug_select_o}, 32'd0);
        dr_scan("bypass", 9, 64'hA5, 65'd0, {55'd0, 8'hA5, 1'b0});

        // Unsupported opcode (EXTEST) acts as BYPASS.
        ir_scan(4'b0000, cap);
        dr_scan("extest", 5, 64'hB, 65'd0, {59'd0, 4'hB, 1'b0});

        // DEBUG: captured IR pattern, select, and debug_tdo passed through.
        ir_scan(4'b1000, cap);
        chk("ir_cap_debug", {28'd0, cap}, 32'h5);
        chk("debug_sel", {31'd0, debug_select_o}, 32'd1);
        tdi_pad_i = 1'b1; #1;
        chk("debug_tdi1", {31'd0, debug_tdi_o}, 32'd1);
        tdi_pad_i = 1'b0; #1;
        chk("debug_tdi0", {31'd0, debug_tdi_o}, 32'd0);
        dr_scan("debug", 8, 64'h3C, 65'h15A, 64'h5A);

        // USERCODE opcode.
        ir_scan(4'b0011, cap);
`ifdef JTAG_TAP_USERCODE_EN
        dr_scan("usercode", 32, 64'hFFFFFFFF, 65'd0, {32'd0, USERCODE});
`else
        dr_scan("usercode_bypass", 8, 64'hFF, 65'd0, 64'hFE);
`endif

        // Every state exits to TEST_LOGIC_RESET after five tms=1 clocks.
        for (int s = 0; s < 16; s++) begin
            trst_n_pad_i = 1'b0; #2; trst_n_pad_i = 1'b1;
            tms_go(paths[s]);
            chk($sformatf("dec_s%0d", s),
                {26'd0, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o,
                 run_test_idle_o, test_logic_reset_o}, {26'd0, decs[s]});
            tms_go("11111");
            chk($sformatf("tlr5_s%0d", s), {31'd0, test_logic_reset_o}, 32'd1);
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
